// File: rtl/video_timing_gen_pkg.sv
// Shared types for the raster timing generator: phase encoding, per-axis
// timing configuration and the colour-bar palette.
package video_timing_pkg;

  localparam int TW = 12;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

  typedef struct packed {
    logic [TW-1:0] active;
    logic [TW-1:0] fp;
    logic [TW-1:0] sync;
    logic [TW-1:0] bp;
    logic          pol;
  } axis_cfg_t;

  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [TW-1:0] phase_len(input axis_cfg_t cfg, input phase_t ph);
    case (ph)
      PH_ACTIVE: return cfg.active;
      PH_FP:     return cfg.fp;
      PH_SYNC:   return cfg.sync;
      default:   return cfg.bp;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video output stream of the timing generator (pixel enable, syncs, blanking,
// counters). RGB exists only when VIDEO_TIMING_GEN_PATTERN_EN is defined.
interface video_timing_gen_if #(parameter int CW = 12);
  logic          CE_PIXEL;
  logic          VGA_HS;
  logic          VGA_VS;
  logic          VGA_HBLANK;
  logic          VGA_VBLANK;
  logic          VGA_DE;
  logic [CW-1:0] H_CNT;
  logic [CW-1:0] V_CNT;
  logic          FRAME_START;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic [23:0]   RGB;

  modport master (output CE_PIXEL, VGA_HS, VGA_VS, VGA_HBLANK, VGA_VBLANK,
                         VGA_DE, H_CNT, V_CNT, FRAME_START, RGB);
  modport slave  (input  CE_PIXEL, VGA_HS, VGA_VS, VGA_HBLANK, VGA_VBLANK,
                         VGA_DE, H_CNT, V_CNT, FRAME_START, RGB);
`else
  modport master (output CE_PIXEL, VGA_HS, VGA_VS, VGA_HBLANK, VGA_VBLANK,
                         VGA_DE, H_CNT, V_CNT, FRAME_START);
  modport slave  (input  CE_PIXEL, VGA_HS, VGA_VS, VGA_HBLANK, VGA_VBLANK,
                         VGA_DE, H_CNT, V_CNT, FRAME_START);
`endif
endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis (H or V): phase FSM with a per-phase counter that advances on step.
//   state     | meaning
//   PH_ACTIVE | visible pixels/lines, counter is the live position
//   PH_FP     | front porch, skipped when its length is 0
//   PH_SYNC   | sync pulse, a length of 0 behaves as 1
//   PH_BP     | back porch, skipped when its length is 0
module video_timing_axis
  import video_timing_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  axis_cfg_t     cfg,
  output phase_t        phase,
  output logic [TW-1:0] cnt,
  output logic          axis_end
);

  phase_t        phase_nxt;
  logic [TW-1:0] cnt_nxt;
  logic          phase_done;
  phase_t        final_phase;

  // cnt+1 >= len also makes a zero-length ACTIVE/SYNC last exactly one step
  assign phase_done  = ((TW+1)'(cnt) + (TW+1)'(1)) >= (TW+1)'(phase_len(cfg, phase));
  assign final_phase = (cfg.bp != '0) ? PH_BP : PH_SYNC;
  assign axis_end    = phase_done && (phase == final_phase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_ACTIVE;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    if (step) begin
      if (phase_done) begin
        cnt_nxt = '0;
        unique case (phase)
          PH_ACTIVE: phase_nxt = (cfg.fp != '0) ? PH_FP : PH_SYNC;
          PH_FP:     phase_nxt = PH_SYNC;
          PH_SYNC:   phase_nxt = (cfg.bp != '0) ? PH_BP : PH_ACTIVE;
          default:   phase_nxt = PH_ACTIVE;
        endcase
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: CE divider, H/V phase FSMs, frame-boundary
// config shadowing and registered sync/blank/DE outputs. Define
// VIDEO_TIMING_GEN_PATTERN_EN to add the 8-bar colour pattern on RGB.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW   = TW,
  parameter int DIVW = 4
) (
  input  logic            CLK_VIDEO,
  input  logic            RESET,
  input  logic [CW-1:0]   H_ACTIVE,
  input  logic [CW-1:0]   H_FP,
  input  logic [CW-1:0]   H_SYNC,
  input  logic [CW-1:0]   H_BP,
  input  logic [CW-1:0]   V_ACTIVE,
  input  logic [CW-1:0]   V_FP,
  input  logic [CW-1:0]   V_SYNC,
  input  logic [CW-1:0]   V_BP,
  input  logic            HS_POL,
  input  logic            VS_POL,
  input  logic [DIVW-1:0] CE_DIV,
  video_timing_gen_if.master vid
);

  axis_cfg_t       h_cfg, v_cfg;
  logic [DIVW-1:0] ce_div, div_cnt;
  logic            started, ce, load;
  logic            line_end, frame_end, h_end, v_end;
  phase_t          h_phase, v_phase;
  logic [TW-1:0]   h_cnt, v_cnt;
  logic            h_act, v_act;

  assign ce        = started && (div_cnt == ce_div);
  assign line_end  = ce && h_end;
  assign frame_end = line_end && v_end;
  // the first clock out of reset only loads the shadow registers
  assign load      = !started || frame_end;
  assign h_act     = (h_phase == PH_ACTIVE);
  assign v_act     = (v_phase == PH_ACTIVE);

  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      started <= 1'b0;
      div_cnt <= '0;
      ce_div  <= '0;
      h_cfg   <= '0;
      v_cfg   <= '0;
    end else begin
      started <= 1'b1;
      div_cnt <= (ce || !started) ? '0 : div_cnt + 1'b1;
      if (load) begin
        ce_div <= CE_DIV;
        h_cfg  <= '{active: TW'(H_ACTIVE), fp: TW'(H_FP), sync: TW'(H_SYNC), bp: TW'(H_BP), pol: HS_POL};
        v_cfg  <= '{active: TW'(V_ACTIVE), fp: TW'(V_FP), sync: TW'(V_SYNC), bp: TW'(V_BP), pol: VS_POL};
      end
    end
  end

  video_timing_axis u_h (
    .clk(CLK_VIDEO), .rst(RESET), .step(ce), .cfg(h_cfg),
    .phase(h_phase), .cnt(h_cnt), .axis_end(h_end)
  );

  video_timing_axis u_v (
    .clk(CLK_VIDEO), .rst(RESET), .step(line_end), .cfg(v_cfg),
    .phase(v_phase), .cnt(v_cnt), .axis_end(v_end)
  );

  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      vid.CE_PIXEL    <= 1'b0;
      vid.VGA_HS      <= 1'b0;
      vid.VGA_VS      <= 1'b0;
      vid.VGA_HBLANK  <= 1'b0;
      vid.VGA_VBLANK  <= 1'b0;
      vid.VGA_DE      <= 1'b0;
      vid.H_CNT       <= '0;
      vid.V_CNT       <= '0;
      vid.FRAME_START <= 1'b0;
    end else begin
      vid.CE_PIXEL <= ce;
      if (ce) begin
        vid.VGA_HS      <= (h_phase == PH_SYNC) ? h_cfg.pol : !h_cfg.pol;
        vid.VGA_VS      <= (v_phase == PH_SYNC) ? v_cfg.pol : !v_cfg.pol;
        vid.VGA_HBLANK  <= !h_act;
        vid.VGA_VBLANK  <= !v_act;
        vid.VGA_DE      <= h_act && v_act;
        vid.H_CNT       <= h_act ? CW'(h_cnt) : '0;
        vid.V_CNT       <= v_act ? CW'(v_cnt) : '0;
        vid.FRAME_START <= h_act && v_act && (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic [TW-1:0] bar_pix, bar_w;
  logic [2:0]    bar_idx;

  assign bar_w = h_cfg.active >> 3;

  // bar index saturates at the last bar when H_ACTIVE is not a multiple of 8
  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      bar_pix <= '0;
      bar_idx <= '0;
      vid.RGB <= '0;
    end else if (ce) begin
      vid.RGB <= (h_act && v_act) ? BAR_RGB[bar_idx] : 24'h0;
      if (!h_act) begin
        bar_pix <= '0;
        bar_idx <= '0;
      end else if (((TW+1)'(bar_pix) + (TW+1)'(1)) >= (TW+1)'(bar_w)) begin
        bar_pix <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pix <= bar_pix + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: per-clock comparison against a
// position-based raster model, a table of timing vectors and corner sequences.
module tb_video_timing_gen;

  localparam int CW   = 12;
  localparam int DIVW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0]   h_a, h_f, h_s, h_b, v_a, v_f, v_s, v_b;
  logic            hp, vp;
  logic [DIVW-1:0] div;

  video_timing_gen_if #(.CW(CW)) vid ();

  video_timing_gen #(.CW(CW), .DIVW(DIVW)) dut (
    .CLK_VIDEO(clk), .RESET(rst),
    .H_ACTIVE(h_a), .H_FP(h_f), .H_SYNC(h_s), .H_BP(h_b),
    .V_ACTIVE(v_a), .V_FP(v_f), .V_SYNC(v_s), .V_BP(v_b),
    .HS_POL(hp), .VS_POL(vp), .CE_DIV(div),
    .vid(vid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: shadow config, raster position, expected pins
  int m_ha, m_hf, m_hs, m_hb, m_va, m_vf, m_vs, m_vb, m_div;
  bit m_hp, m_vp, m_started;
  int m_since, mx, my;
  logic [63:0] exp_pins = '0;
  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, div;
    int line, frame, de, hsw, hsoff;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [63:0] dut_pins();
    logic [63:0] p = '0;
    p[30:0] = {vid.CE_PIXEL, vid.VGA_HS, vid.VGA_VS, vid.VGA_HBLANK, vid.VGA_VBLANK,
               vid.VGA_DE, vid.H_CNT, vid.V_CNT, vid.FRAME_START};
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    p[54:31] = vid.RGB;
`endif
    return p;
  endfunction

  function automatic int eff(input int len);
    return (len == 0) ? 1 : len;
  endfunction

  function automatic int total(input int a, input int f, input int s, input int b);
    return eff(a) + f + eff(s) + b;
  endfunction

  // 0 active, 1 front porch, 2 sync, 3 back porch
  function automatic int phase_at(input int pos, input int a, input int f, input int s);
    if (pos < eff(a)) return 0;
    if (pos < eff(a) + f) return 1;
    if (pos < eff(a) + f + eff(s)) return 2;
    return 3;
  endfunction

  function automatic logic [63:0] decode(input int x, input int y);
    logic [63:0] p = '0;
    int hph = phase_at(x, m_ha, m_hf, m_hs);
    int vph = phase_at(y, m_va, m_vf, m_vs);
    bit de = (hph == 0) && (vph == 0);
    int bw, idx;
    p[30]    = 1'b1;
    p[29]    = (hph == 2) ? m_hp : !m_hp;
    p[28]    = (vph == 2) ? m_vp : !m_vp;
    p[27]    = (hph != 0);
    p[26]    = (vph != 0);
    p[25]    = de;
    p[24:13] = (hph == 0) ? 12'(x) : 12'd0;
    p[12:1]  = (vph == 0) ? 12'(y) : 12'd0;
    p[0]     = (x == 0) && (y == 0);
    bw = m_ha >> 3;
    idx = (bw == 0) ? x : x / bw;
    if (idx > 7) idx = 7;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    if (de) p[54:31] = bar_rgb[idx];
`endif
    return p;
  endfunction

  task automatic load_shadow();
    m_ha = h_a; m_hf = h_f; m_hs = h_s; m_hb = h_b;
    m_va = v_a; m_vf = v_f; m_vs = v_s; m_vb = v_b;
    m_hp = hp;  m_vp = vp;  m_div = div;
  endtask

  task automatic model_reset();
    m_started = 0; m_since = 0; mx = 0; my = 0; exp_pins = '0;
    m_ha = 0; m_hf = 0; m_hs = 0; m_hb = 0; m_va = 0; m_vf = 0; m_vs = 0; m_vb = 0;
    m_hp = 0; m_vp = 0; m_div = 0;
  endtask

  task automatic model_clock();
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_started) begin
      load_shadow();
      m_started = 1; m_since = 0; exp_pins[30] = 1'b0;
      return;
    end
    if (m_since == m_div) begin
      exp_pins = decode(mx, my);
      mx++;
      if (mx == total(m_ha, m_hf, m_hs, m_hb)) begin
        mx = 0; my++;
        if (my == total(m_va, m_vf, m_vs, m_vb)) begin
          my = 0;
          load_shadow();
        end
      end
      m_since = 0;
    end else begin
      m_since++;
      exp_pins[30] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    cyc++;
    @(negedge clk);
    chk("pins", dut_pins(), exp_pins);
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, d);
    h_a = CW'(ha); h_f = CW'(hf); h_s = CW'(hs); h_b = CW'(hb);
    v_a = CW'(va); v_f = CW'(vf); v_s = CW'(vs); v_b = CW'(vb);
    hp = hpol[0]; vp = vpol[0]; div = DIVW'(d);
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2));
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    #1;
    chk("async_reset", dut_pins(), 64'h0);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic measure(input vec_t v);
    int t_fs0 = -1, t_fs1 = -1, t_hs1 = -1, t_hse = -1, t_hs2 = -1, de_cnt = 0;
    bit prev_fs = 0, prev_hsa = 0, hsa;
    for (int t = 0; t < 20000 && t_fs1 < 0; t++) begin
      tick();
      if (vid.FRAME_START && !prev_fs) begin
        if (t_fs0 < 0) t_fs0 = t; else t_fs1 = t;
      end
      prev_fs = vid.FRAME_START;
      if (t_fs0 >= 0 && t_fs1 < 0) begin
        if (vid.VGA_DE) de_cnt++;
        hsa = (vid.VGA_HS == v.hp[0]);
        if (hsa && !prev_hsa) begin
          if (t_hs1 < 0) t_hs1 = t; else if (t_hs2 < 0) t_hs2 = t;
        end
        if (!hsa && prev_hsa && t_hs1 >= 0 && t_hse < 0) t_hse = t;
        prev_hsa = hsa;
      end
    end
    chk("first_fs_latency", t_fs0, v.div + 1);
    chk("frame_period", t_fs1 - t_fs0, v.frame);
    chk("de_per_frame", de_cnt, v.de);
    chk("line_period", t_hs2 - t_hs1, v.line);
    chk("hs_width", t_hse - t_hs1, v.hsw);
    chk("hs_offset", t_hs1 - t_fs0, v.hsoff);
  endtask

  initial begin
    vecs[0] = '{16, 2, 3, 4, 6, 1, 2, 1, 0, 0, 0,   25,  250,   96,  3,  18};
    vecs[1] = '{ 4, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0,    5,   20,   12,  1,   4};
    vecs[2] = '{16, 2, 3, 4, 6, 1, 2, 1, 0, 1, 3,  100, 1000,  384, 12,  72};
    vecs[3] = '{640, 16, 96, 48, 4, 1, 1, 1, 0, 0, 0, 800, 5600, 2560, 96, 656};
    vecs[4] = '{ 8, 0, 1, 0, 2, 0, 0, 1, 1, 1, 1,   18,   72,   32,  2,  16};
    vecs[5] = '{ 0, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0,    5,   10,    1,  2,   2};

    model_reset();
    set_cfg(16, 2, 3, 4, 6, 1, 2, 1, 0, 0, 0);
    repeat (2) tick();

    foreach (vecs[i]) begin
      set_cfg(vecs[i].ha, vecs[i].hf, vecs[i].hs, vecs[i].hb, vecs[i].va, vecs[i].vf,
              vecs[i].vs, vecs[i].vb, vecs[i].hp, vecs[i].vp, vecs[i].div);
      apply_reset(3);
      measure(vecs[i]);
    end

    // mid-frame H_ACTIVE change only takes effect at the next frame
    begin
      int fs_n = 0, run = 0, runs_f1 = 0, last_f1 = 0, first_f2 = 0;
      bit prev_de = 0, prev_fs = 0, changed = 0;
      set_cfg(640, 16, 96, 48, 4, 1, 1, 1, 0, 0, 0);
      apply_reset(3);
      for (int t = 0; t < 20000 && first_f2 == 0; t++) begin
        tick();
        if (vid.FRAME_START && !prev_fs) fs_n++;
        prev_fs = vid.FRAME_START;
        if (vid.VGA_DE) run++;
        else if (prev_de) begin
          if (fs_n == 1) begin runs_f1++; last_f1 = run; end
          else if (fs_n == 2) first_f2 = run;
          run = 0;
        end
        prev_de = vid.VGA_DE;
        if (fs_n == 1 && runs_f1 == 2 && !changed) begin
          h_a = CW'(320);
          changed = 1;
        end
      end
      chk("de_width_old_frame", last_f1, 640);
      chk("de_runs_old_frame", runs_f1, 4);
      chk("de_width_new_frame", first_f2, 320);
    end

    // reset mid-line, then a clean frame start with no partial line
    for (int k = 0; k < 2; k++) begin
      int d = k * 3, lat = -1;
      bit early_de = 0;
      set_cfg(640, 16, 96, 48, 4, 1, 1, 1, 0, 0, d);
      apply_reset(2);
      for (int t = 0; t < 30000; t++) begin
        tick();
        if (vid.VGA_DE && vid.V_CNT == 12'd2 && vid.H_CNT == 12'd300) break;
      end
      chk("reached_reset_point", {vid.V_CNT, vid.H_CNT}, {12'd2, 12'd300});
      #3;
      apply_reset(5);
      for (int t = 0; t < 50 && lat < 0; t++) begin
        tick();
        if (vid.FRAME_START) lat = t;
        else if (vid.VGA_DE) early_de = 1;
      end
      chk("fs_latency_after_reset", lat, d + 1);
      chk("no_partial_frame", early_de, 0);
    end

    // random configs with random mid-frame input changes and resets
    for (int s = 0; s < 15; s++) begin
      rand_cfg();
      apply_reset(2);
      for (int c = 0; c < 2000; c++) begin
        tick();
        if ($urandom_range(0, 49) == 0) rand_cfg();
        if ($urandom_range(0, 1499) == 0) apply_reset($urandom_range(1, 4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Programmable raster timing generator: source side of the CE_PIXEL / VGA_HS / VGA_VS / VGA_DE stream that cropping, aspect-ratio and integer-scaling logic consume.
- Produces a pixel clock-enable, sync pulses, blanking, DE and live H/V counters from runtime timing registers.
- Sits at core video output, ahead of crop/scaler and the framework video path.

Parameters:
- CW, 12, width of all timing inputs and counters.
- DIVW, 4, width of the CE divider input.

Ports:
- CLK_VIDEO  in  1  video clock
- RESET  in  1  asynchronous, active-high reset
- H_ACTIVE, H_FP, H_SYNC, H_BP  in  CW each  horizontal phase lengths, in pixels
- V_ACTIVE, V_FP, V_SYNC, V_BP  in  CW each  vertical phase lengths, in lines
- HS_POL, VS_POL  in  1 each  sync polarity (1 = active-high)
- CE_DIV  in  DIVW  CE_PIXEL period minus 1, in clocks
- CE_PIXEL  out  1  pixel enable, one-clock pulse
- VGA_HS, VGA_VS  out  1 each  syncs with polarity applied
- VGA_HBLANK, VGA_VBLANK  out  1 each  blanking
- VGA_DE  out  1  ~HBLANK & ~VBLANK
- H_CNT, V_CNT  out  CW each  position within the active area; 0 during blanking
- FRAME_START  out  1  one-CE pulse on the first active pixel of a frame

Behaviour:
- Reset: all counters 0, both phase FSMs in ACTIVE, CE divider 0, shadow config cleared. All outputs are 0, including syncs, regardless of polarity.
- Reset release: shadow registers load on the first clock after RESET deasserts. The first CE_PIXEL follows CE_DIV+1 clocks later.
- CE divider: free-running counter. CE_PIXEL = 1 when the count equals the shadow CE_DIV, then the count wraps to 0. CE_DIV = 0 gives CE_PIXEL every clock.
- All raster state advances only on clocks where CE_PIXEL = 1.
- Outputs are registered and update on the same CE_PIXEL as the counter step, so there is one clock of latency from the internal state to the pins.
- Horizontal FSM states, in order: ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
  - A per-phase counter runs 0..len-1, then moves to the next state.
  - FP or BP length 0: phase is skipped.
  - ACTIVE or SYNC length 0: treated as length 1.
- Vertical FSM: same four states. It steps once per line, on the CE where the horizontal FSM leaves its last non-skipped phase (end of line).
- Output decode:
  - VGA_HS = HS_POL when H is in SYNC, else ~HS_POL. VGA_VS is the same with VS_POL and V.
  - HBLANK = (H not in ACTIVE). VBLANK = (V not in ACTIVE).
  - VS edges align to the start of a line (same CE as the H wrap to ACTIVE).
- H_CNT / V_CNT: equal the ACTIVE phase counters while in ACTIVE, else 0. Width is CW, with no overflow since lengths are at most 2^CW-1.
- Config shadowing: every timing input, both polarities and CE_DIV are sampled into shadow registers only at the frame boundary, i.e. the CE where V leaves its last phase and H ends the line. Mid-frame input changes have no effect until that boundary.
- FRAME_START: high for exactly the CE period of pixel (0,0) of ACTIVE/ACTIVE.
- Simultaneous events: the frame boundary, config load and FSM wrap occur on the same CE. The new frame uses the new shadow values from its first pixel.
- Line and frame totals equal the sums of the four phase lengths, after the zero-length rules. Totals above 2^CW are not supported; per-phase counters never wrap.
- Reset mid-frame: immediate return to reset state. There is no partial-frame output after release.

Optional Feature:
- Macro VIDEO_TIMING_GEN_PATTERN_EN.
- With it defined: adds output RGB (24 bits) carrying 8 vertical colour bars, each H_ACTIVE/8 pixels wide. The bar index comes from a bar counter that steps every H_ACTIVE>>3 pixels, with no divider. Bar order is white, yellow, cyan, green, magenta, red, blue, black. RGB is 0 whenever DE = 0.
- Without it: no RGB port and no bar logic.

Decomposition:
- Package video_timing_pkg holds:
  - phase_t enum {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP};
  - the timing-config struct (four lengths plus polarity);
  - the bar colour constant array.
- Sub-module video_timing_axis: one phase FSM with counter, step input, shadow-config input and end-of-axis output. It is instantiated twice, for H and V.

Test Plan:
- 640x480 timing (H 640/16/96/48, V 480/10/2/33), CE_DIV=0, HS_POL=VS_POL=0:
  - 800 clocks between HS falling edges;
  - 420000 clocks between FRAME_START pulses;
  - 307200 DE cycles per frame;
  - HS low for 96 clocks, starting 656 clocks after DE rises.
- CE_DIV=3, same timing: CE_PIXEL every 4 clocks; frame period 1680000 clocks; every output is stable between CEs.
- Change H_ACTIVE 640 -> 320 at mid-frame line 100: the current frame keeps 640-wide DE; the next frame has 320-wide DE from its FRAME_START.
- H_FP=0, H_BP=0, H_SYNC=0, H_ACTIVE=4: line period of 5 CEs (4 active + 1 sync); FP and BP are never entered.
- RESET asserted at line 200, pixel 300, held 5 clocks: outputs go to 0 asynchronously; after release, the first FRAME_START arrives exactly at (0,0) timing with no partial line.
- With VIDEO_TIMING_GEN_PATTERN_EN and H_ACTIVE=640: RGB = FFFFFF for pixels 0..79, FFFF00 for 80..159, ..., 000000 for 560..639; RGB is 0 in blanking.
